// File: rtl/booth_pp_accumulator.sv
// ---------------------------------------------------------------------------
// booth_pp_accumulator
//   Consumer end of the radix-4 Booth partial-product path. It accepts a
//   bundle of NUM_PP signed PP_W-bit partial products over a valid/ready
//   handshake, sums them PP_PER_CYCLE terms per clock, and presents the
//   PP_W-bit two's-complement product on a valid/ready output.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : pp_flat carries a valid bundle
//   in_ready   : block can accept a bundle (registered)
//   pp_flat    : partial products, pp[i] = pp_flat[i*PP_W +: PP_W]
//   out_valid  : product is valid (registered)
//   out_ready  : downstream accepts the product
//   product    : sum of all partial products modulo 2^PP_W (registered)
//   busy       : high while accumulating or holding a result (registered)
// ---------------------------------------------------------------------------
module booth_pp_accumulator #(
  parameter int NUM_PP       = 16,
  parameter int PP_W         = 64,
  parameter int PP_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_PP*PP_W-1:0] pp_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PP_W-1:0]        product,
  output logic                   busy
);

  localparam int BUF_W  = NUM_PP * PP_W;
  localparam int STEP_W = PP_PER_CYCLE * PP_W;
  localparam int K      = NUM_PP / PP_PER_CYCLE;
  localparam int CNT_W  = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // The bundle must split evenly into per-cycle groups.
  generate
    if ((NUM_PP % PP_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("booth_pp_accumulator: NUM_PP must be a multiple of PP_PER_CYCLE");
    end
  endgenerate

  // Sum of the PP_PER_CYCLE partial products in the lowest group.
  function automatic logic [PP_W-1:0] group_sum(input logic [STEP_W-1:0] grp);
    logic [PP_W-1:0] s;
    s = '0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      s = s + grp[j*PP_W +: PP_W];
    end
    return s;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [PP_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PP_W-1:0]  product_q, product_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [PP_W-1:0]  sum_s;

  // Running sum plus the group currently at the bottom of the buffer.
  // The buffer shifts down one group per ACCUM cycle, so the active group
  // always sits in the low bits and no dynamic indexing is needed.
  assign sum_s = acc_q + group_sum(buf_q[STEP_W-1:0]);

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d      = pp_flat;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        acc_d = sum_s;
        buf_d = buf_q >> STEP_W;
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          product_d   = sum_s;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        cnt_d       = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// ---------------------------------------------------------------------------
// tb_booth_pp_accumulator
//   Directed bench for booth_pp_accumulator. Bundles are built from
//   radix-4 Booth recoding of 32-bit operands; expected products are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_booth_pp_accumulator;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] pp_flat;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   product;
  logic          busy;

  int checks = 0;
  int errors = 0;

  booth_pp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_flat   (pp_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Radix-4 Booth partial products of a*b (b as signed 32-bit).
  function automatic logic [1023:0] booth(input logic signed [31:0] a, input logic [31:0] b);
    logic [1023:0] res;
    logic [32:0]   bx;
    int            d;
    longint        p;
    res = '0;
    bx  = {b, 1'b0};
    for (int i = 0; i < 16; i++) begin
      d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
      p = longint'(a) * longint'(d);
      res[i*64 +: 64] = p <<< (2 * i);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Present a bundle for one accept edge, optionally corrupt it right
  // after, and return edges from accept until out_valid is seen.
  task automatic run_op(input logic [1023:0] bundle, input logic corrupt, output int lat);
    pp_flat  = bundle;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (corrupt) pp_flat = {1024{1'b1}};
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int nv, t1, t2;
    logic [63:0] p1, p2;
    logic [1023:0] wrap_b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pp_flat   = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_product",   product,        64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with garbage inputs and in_valid low: nothing happens.
    pp_flat = {1024{1'b1}};
    repeat (3) @(negedge clk);
    check("idle_busy",     64'(busy),     64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // -7 * 6
    out_ready = 1'b1;
    run_op(booth(-32'sd7, 32'd6), 1'b0, lat);
    check("m7x6_latency", 64'(lat), 64'd4);
    check("m7x6_product", product, 64'hFFFF_FFFF_FFFF_FFD6);
    @(negedge clk);
    check("m7x6_valid_drop", 64'(out_valid), 64'd0);
    check("m7x6_in_ready",   64'(in_ready),  64'd1);
    check("m7x6_busy",       64'(busy),      64'd0);

    // All partial products -1.
    run_op({1024{1'b1}}, 1'b0, lat);
    check("ones_latency", 64'(lat), 64'd4);
    check("ones_product", product, 64'hFFFF_FFFF_FFFF_FFF0);
    @(negedge clk);

    // Two 0x8000... terms wrap to zero.
    wrap_b = '0;
    wrap_b[63:0]   = 64'h8000_0000_0000_0000;
    wrap_b[127:64] = 64'h8000_0000_0000_0000;
    run_op(wrap_b, 1'b0, lat);
    check("wrap_product", product, 64'd0);
    @(negedge clk);

    // Backpressure: hold the result for 10 cycles with in_valid high.
    out_ready = 1'b0;
    run_op(booth(32'sd3, 32'd4), 1'b0, lat);
    check("bp_latency", 64'(lat), 64'd4);
    check("bp_product", product, 64'd12);
    pp_flat  = booth(32'sd9, 32'd9);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid",    64'(out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(in_ready),  64'd0);
      check("bp_hold_busy",     64'(busy),      64'd1);
      check("bp_hold_product",  product,        64'd12);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_release_valid",    64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready),  64'd1);
    check("bp_release_product",  product,        64'd12);
    @(negedge clk);
    check("bp_no_accept_busy", 64'(busy), 64'd0);

    // Back-to-back with in_valid held; second bundle replaces the first
    // on the input right after the first accept.
    nv = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
    pp_flat  = booth(32'sh7FFF_FFFF, 32'h7FFF_FFFF);
    in_valid = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) pp_flat = booth(32'sh8000_0000, 32'h8000_0000);
      if (i == 7) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        if (nv == 0) begin t1 = i; p1 = product; end
        else begin t2 = i; p2 = product; end
        nv++;
      end
    end
    check("b2b_count",    64'(nv),      64'd2);
    check("b2b_first_t",  64'(t1),      64'd5);
    check("b2b_spacing",  64'(t2 - t1), 64'd6);
    check("b2b_product1", p1, 64'h3FFF_FFFF_0000_0001);
    check("b2b_product2", p2, 64'h4000_0000_0000_0000);

    // Asynchronous reset during the second ACCUM cycle.
    pp_flat  = booth(32'sd11, 32'd13);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd1);
    check("arst_busy",      64'(busy),      64'd0);
    check("arst_product",   product,        64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(booth(32'sd3, 32'd5), 1'b0, lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_product", product, 64'd15);
    @(negedge clk);

    // Input corrupted right after accept: latched bundle is used.
    run_op(booth(32'sd100, -32'sd3), 1'b1, lat);
    check("corrupt_latency", 64'(lat), 64'd4);
    check("corrupt_product", product, 64'hFFFF_FFFF_FFFF_FED4);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
Consumer end of the radix-4 Booth partial-product interface. Accepts the flattened bundle of 16 signed 64-bit partial products from the Booth generator with a valid/ready handshake. Sums them iteratively, PP_PER_CYCLE terms per clock, and presents the 64-bit two's-complement product on a valid/ready output. It sits between the Booth partial-product stage and the PE's result writeback in the multiply path.

Parameters:
NUM_PP, 16, number of partial products per operation.
PP_W, 64, width of each partial product and of the product.
PP_PER_CYCLE, 4, partial products summed per ACCUM cycle. NUM_PP % PP_PER_CYCLE must be 0; any other value is an elaboration error.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  pp_flat is valid.
in_ready  output  1  block can accept a new bundle.
pp_flat  input  NUM_PP*PP_W  partial products, signed; pp[i] = pp_flat[i*PP_W +: PP_W], pp[0] in the LSBs.
out_valid  output  1  product is valid.
out_ready  input  1  downstream accepts product.
product  output  PP_W  sum of all partial products, modulo 2^PP_W.
busy  output  1  high in ACCUM or DONE.

Behaviour:
- States: IDLE, ACCUM, DONE. Define K = NUM_PP / PP_PER_CYCLE (default 4).
- Reset, asynchronous, any state: state=IDLE, acc=0, cnt=0, pp buffer=0, product=0, out_valid=0, in_ready=1, busy=0. An in-flight operation is discarded and no output is produced for it.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch all of pp_flat into an internal buffer, set acc=0, cnt=0, go to ACCUM.
  - pp_flat is ignored after the accept edge; the source may change it freely.
- ACCUM:
  - in_ready=0.
  - Each edge: acc <= acc + sum of buffered pp[cnt*PP_PER_CYCLE + j], j=0..PP_PER_CYCLE-1; cnt <= cnt+1.
  - All additions are PP_W-bit two's complement and wrap silently; there is no overflow flag.
  - On the edge where cnt = K-1: perform the final add, load product with the final sum, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; product and out_valid stay stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE. product keeps its last value.
  - in_ready=0 in DONE. An in_valid asserted during DONE is not accepted until IDLE.
- Latency: accept on edge E0; out_valid is first high after edge E0+K (default 4 edges after the accept).
- Throughput with out_ready held at 1: one operation every K+2 cycles.
- Outputs are registered: out_valid, product, in_ready and busy depend only on state and registers, never combinationally on in_valid or out_ready.
- X-safety: nothing is latched and no state changes while in_valid=0 in IDLE.

Test Plan:
- Booth bundle from A=-7, B=6 on in_valid for 1 cycle, out_ready=1 -> out_valid rises exactly 4 edges after the accept; product=0xFFFF_FFFF_FFFF_FFD6 (-42); out_valid drops after 1 cycle.
- All 16 pp = 0xFFFF_FFFF_FFFF_FFFF -> product=0xFFFF_FFFF_FFFF_FFF0 (-16). Then pp[0]=pp[1]=0x8000_0000_0000_0000, rest 0 -> product=0 (wrap, no flag).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> product, out_valid=1 and in_ready=0 held constant throughout; in_valid held high is not accepted. Raising out_ready -> handshake, IDLE, in_ready=1 the next cycle.
- Back-to-back: Booth bundles for A=0x7FFF_FFFF, B=0x7FFF_FFFF, then A=-2^31, B=-2^31, in_valid held, out_ready=1 -> products 0x3FFF_FFFF_0000_0001 then 0x4000_0000_0000_0000, accepts spaced 6 cycles apart.
- Reset mid-operation: assert rst on the 2nd ACCUM cycle, asynchronously between edges -> outputs immediately in reset state (out_valid=0, in_ready=1, busy=0, product=0); the next operation (A=3, B=5) yields 15 with normal latency.
- Input change after accept: corrupt pp_flat on the cycle after the accept -> product still equals the sum of the originally latched bundle.
